// File: rtl/spi_arb_pkg.sv
// Shared types and widths for the SPI word arbiter.
package spi_arb_pkg;

  localparam int SPI_WORD_W = 16;
  localparam int SPI_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT_LO = 3'd2,
    WAIT_HI = 3'd3,
    RESP    = 3'd4
  } arb_state_t;

endpackage

// File: rtl/spi_word_arbiter_if.sv
// Requester and SPI-sender signals of the word arbiter.
// The slave modport is the arbiter's view; master is the environment's.
interface spi_word_arbiter_if
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // requester side
  logic [NUM_REQ-1:0]            i_Req_Valid;
  logic [SPI_WORD_W*NUM_REQ-1:0] i_Req_Word;
  logic [NUM_REQ-1:0]            o_Req_Ready;
  logic [NUM_REQ-1:0]            o_Rsp_Valid;
  logic [SPI_WORD_W-1:0]         o_Rsp_Word;
  logic                          o_Rsp_Err;
  logic                          o_Busy;
  logic [IDX_W-1:0]              o_Grant_Id;

  // sender side
  logic                          o_SPI_Start;
  logic [SPI_WORD_W-1:0]         o_SPI_Word;
  logic                          i_SPI_Byte_DV;
  logic [SPI_BYTE_W-1:0]         i_SPI_Byte;

  modport slave (
    input  i_Req_Valid, i_Req_Word, i_SPI_Byte_DV, i_SPI_Byte,
    output o_Req_Ready, o_Rsp_Valid, o_Rsp_Word, o_Rsp_Err, o_Busy,
           o_Grant_Id, o_SPI_Start, o_SPI_Word
  );

  modport master (
    output i_Req_Valid, i_Req_Word, i_SPI_Byte_DV, i_SPI_Byte,
    input  o_Req_Ready, o_Rsp_Valid, o_Rsp_Word, o_Rsp_Err, o_Busy,
           o_Grant_Id, o_SPI_Start, o_SPI_Word
  );

endinterface

// File: rtl/spi_word_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping past the top index.
module spi_rr_pick #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   grant,
  output logic               any
);

  logic [IDX_W-1:0]   cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_hit;

  // cand_idx[gi] is the requester sitting gi places after the pointer
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      assign sum = {1'b0, ptr} + (IDX_W+1)'(gi);
      assign cand_idx[gi] = (sum >= (IDX_W+1)'(NUM_REQ))
                          ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                          : sum[IDX_W-1:0];
      assign cand_hit[gi] = req[cand_idx[gi]];
    end
  endgenerate

  // Smallest offset wins: scan downward so the nearest hit is written last
  always_comb begin
    grant = '0;
    any   = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand_hit[i]) begin
        grant = cand_idx[i];
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_word_arbiter.sv
// Round-robin sharing of one 16-bit SPI word sender among NUM_REQ
// requesters. One word per grant; the two returned bytes (low first) are
// assembled and handed back to the granted requester. A watchdog closes
// transfers whose byte-done pulses stop arriving.
module spi_word_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic               i_Clk,
  input logic               i_Rst_L,
  spi_word_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  arb_state_t state_reg, state_next;

  logic [IDX_W-1:0]      rr_ptr_reg, rr_ptr_next;
  logic [IDX_W-1:0]      grant_reg, grant_next;
  logic [WD_W-1:0]       wd_reg, wd_next, wd_inc;
  logic [SPI_BYTE_W-1:0] rsp_lo_reg, rsp_lo_next;
  logic [SPI_WORD_W-1:0] rsp_word_reg, rsp_word_next;
  logic                  rsp_err_reg, rsp_err_next;
  logic [SPI_WORD_W-1:0] spi_word_reg, spi_word_next;
  logic                  spi_start_reg, spi_start_next;
  logic [NUM_REQ-1:0]    req_ready_reg, req_ready_next;
  logic [NUM_REQ-1:0]    rsp_valid_reg, rsp_valid_next;
  logic                  busy_reg, busy_next;

  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  logic                  wd_expired;

  logic [SPI_WORD_W-1:0] req_word_arr [NUM_REQ];

  // Unpack the flat request word bus into one word per requester
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_word
      assign req_word_arr[gi] = bus.i_Req_Word[gi*SPI_WORD_W +: SPI_WORD_W];
    end
  endgenerate

  spi_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req   (bus.i_Req_Valid),
    .ptr   (rr_ptr_reg),
    .grant (pick_idx),
    .any   (pick_any)
  );

  // Saturating count; expiry only matters when no byte arrives that cycle
  assign wd_inc     = (wd_reg == WD_MAX) ? wd_reg : wd_reg + 1'b1;
  assign wd_expired = (wd_reg == WD_LAST);

  // Next-state and next-output decode
  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    grant_next     = grant_reg;
    wd_next        = wd_reg;
    rsp_lo_next    = rsp_lo_reg;
    rsp_word_next  = rsp_word_reg;
    rsp_err_next   = rsp_err_reg;
    spi_word_next  = spi_word_reg;
    spi_start_next = 1'b0;
    req_ready_next = '0;
    rsp_valid_next = '0;

    unique case (state_reg)
      IDLE: begin
        if (pick_any) begin
          grant_next     = pick_idx;
          spi_word_next  = req_word_arr[pick_idx];
          req_ready_next = NUM_REQ'(1) << pick_idx;
          spi_start_next = 1'b1;
          state_next     = START;
        end
      end

      START: begin
        wd_next     = '0;
        rsp_lo_next = '0;
        state_next  = WAIT_LO;
      end

      WAIT_LO: begin
        if (bus.i_SPI_Byte_DV) begin
          rsp_lo_next = bus.i_SPI_Byte;
          // the DV cycle itself counts as the first cycle of the new gap
          wd_next     = WD_W'(1);
          state_next  = WAIT_HI;
        end else if (wd_expired) begin
          rsp_word_next  = '0;
          rsp_err_next   = 1'b1;
          rsp_valid_next = NUM_REQ'(1) << grant_reg;
          state_next     = RESP;
        end else begin
          wd_next = wd_inc;
        end
      end

      WAIT_HI: begin
        if (bus.i_SPI_Byte_DV) begin
          rsp_word_next  = {bus.i_SPI_Byte, rsp_lo_reg};
          rsp_err_next   = 1'b0;
          rsp_valid_next = NUM_REQ'(1) << grant_reg;
          state_next     = RESP;
        end else if (wd_expired) begin
          rsp_word_next  = {{SPI_BYTE_W{1'b0}}, rsp_lo_reg};
          rsp_err_next   = 1'b1;
          rsp_valid_next = NUM_REQ'(1) << grant_reg;
          state_next     = RESP;
        end else begin
          wd_next = wd_inc;
        end
      end

      RESP: begin
        rr_ptr_next = (grant_reg == LAST_IDX) ? '0 : grant_reg + 1'b1;
        state_next  = IDLE;
      end

      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      grant_reg     <= '0;
      wd_reg        <= '0;
      rsp_lo_reg    <= '0;
      rsp_word_reg  <= '0;
      rsp_err_reg   <= 1'b0;
      spi_word_reg  <= '0;
      spi_start_reg <= 1'b0;
      req_ready_reg <= '0;
      rsp_valid_reg <= '0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      grant_reg     <= grant_next;
      wd_reg        <= wd_next;
      rsp_lo_reg    <= rsp_lo_next;
      rsp_word_reg  <= rsp_word_next;
      rsp_err_reg   <= rsp_err_next;
      spi_word_reg  <= spi_word_next;
      spi_start_reg <= spi_start_next;
      req_ready_reg <= req_ready_next;
      rsp_valid_reg <= rsp_valid_next;
      busy_reg      <= busy_next;
    end
  end

  assign bus.o_Req_Ready = req_ready_reg;
  assign bus.o_Rsp_Valid = rsp_valid_reg;
  assign bus.o_Rsp_Word  = rsp_word_reg;
  assign bus.o_Rsp_Err   = rsp_err_reg;
  assign bus.o_Busy      = busy_reg;
  assign bus.o_Grant_Id  = grant_reg;
  assign bus.o_SPI_Start = spi_start_reg;
  assign bus.o_SPI_Word  = spi_word_reg;

endmodule
